// File: rtl/tt_ran_sequencer.sv
// TRNG sequencer: gates the ring, paces key sampling, runs a
// repetition-count health test and hands keys out over valid/ready.
//
// Ports:
//   clk            system clock (rising edge)
//   rst_n          synchronous reset, active low
//   start          level request to generate keys
//   key_in         sampled key, valid the cycle after sample
//   key_ready      consumer accepts key_out when key_valid
//   startring      ring-oscillator enable
//   sample         one-cycle sample strobe
//   key_out        captured key
//   key_valid      key_out holds an unconsumed key
//   busy           sequencer not idle
//   fault          sticky repetition health failure
//   keys_delivered completed handshakes, wraps mod 256
module tt_ran_sequencer #(
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 16,
  parameter int REP_LIMIT     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] key_in,
  input  logic       key_ready,
  output logic       startring,
  output logic       sample,
  output logic [3:0] key_out,
  output logic       key_valid,
  output logic       busy,
  output logic       fault,
  output logic [7:0] keys_delivered
);

  localparam int CMAX =
    (WARMUP_CYCLES > SAMPLE_DIV) ?
    WARMUP_CYCLES : SAMPLE_DIV;
  localparam int CW =
    (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  localparam logic [CW-1:0] WU_LAST =
    CW'(WARMUP_CYCLES - 1);
  localparam logic [CW-1:0] SD_LAST =
    CW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REP_MAX =
    RW'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_SAMPLE,
    S_CAPTURE,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic [RW-1:0]   rep_new;
  logic [3:0]      prev_q, prev_d;
  logic            hasp_q, hasp_d;
  logic [3:0]      key_q, key_d;
  logic [7:0]      kd_q, kd_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      prev_q  <= '0;
      hasp_q  <= 1'b0;
      key_q   <= '0;
      kd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      hasp_q  <= hasp_d;
      key_q   <= key_d;
      kd_q    <= kd_d;
    end
  end

  // Run length including the key being captured now.
  // Never exceeds REP_LIMIT, since hitting it halts.
  always_comb begin
    rep_new = RW'(1);
    if (hasp_q && (key_in == prev_q)) begin
      rep_new = rep_q + RW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    prev_d  = prev_q;
    hasp_d  = hasp_q;
    key_d   = key_q;
    kd_d    = kd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WARMUP;
          cnt_d   = '0;
          hasp_d  = 1'b0;
          rep_d   = '0;
        end
      end
      S_WARMUP: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (cnt_q == WU_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (cnt_q == SD_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        rep_d  = rep_new;
        prev_d = key_in;
        hasp_d = 1'b1;
        if (rep_new == REP_MAX) begin
          state_d = S_FAULT;
        end else begin
          key_d   = key_in;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (key_ready) begin
          kd_d = kd_q + 8'd1;
          if (start) begin
            state_d = S_SAMPLE;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A start drop in the last sample slot suppresses
  // the strobe, matching the abort to IDLE.
  assign sample = (state_q == S_SAMPLE) &&
                  (cnt_q == SD_LAST) && start;

  assign startring = (state_q == S_WARMUP)  ||
                     (state_q == S_SAMPLE)  ||
                     (state_q == S_CAPTURE) ||
                     (state_q == S_HOLD);

  assign key_valid      = (state_q == S_HOLD);
  assign busy           = (state_q != S_IDLE);
  assign fault          = (state_q == S_FAULT);
  assign key_out        = key_q;
  assign keys_delivered = kd_q;

endmodule
